// File: rtl/uparc_iter_idiv.sv
// ---------------------------------------------------------------------------
// uparc_iter_idiv -- iterative restoring integer divider (IMulDivU datapath)
//
// Retires BITS_PER_CYCLE quotient bits per clock. Signed or unsigned
// operation is selected per request. The result is packed as
// {remainder, quotient} so it can be written straight into HI/LO.
//
// Parameters:
//   WIDTH          operand width (multiple of BITS_PER_CYCLE)
//   BITS_PER_CYCLE quotient bits per iteration: 1, 2 or 4
//
// Ports:
//   clk      clock, rising edge
//   nrst     asynchronous active-low reset
//   dividend dividend, sampled on an accepted start
//   divider  divisor, sampled on an accepted start
//   start    start request, accepted only while ready=1
//   signd    1 = two's-complement signed divide, 0 = unsigned
//   abort    cancel the operation in flight (or block a start in IDLE)
//   ready    1 = idle and remquot/dz valid
//   remquot  {remainder, quotient}
//   dz       last completed operation had a zero divisor
//
// Optional build macro UPARC_IDIV_EARLY_OUT_EN: operations whose divisor is
// zero or whose dividend magnitude is below the divisor magnitude skip the
// iteration phase. Results are identical; only latency changes.
// ---------------------------------------------------------------------------
module uparc_iter_idiv #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divider,
  input  logic                 start,
  input  logic                 signd,
  input  logic                 abort,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   remquot,
  output logic                 dz
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam int RW    = WIDTH + BITS_PER_CYCLE;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo_acc;
  logic [RW-1:0]    rem_acc;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_orig;
  logic             neg_quo;
  logic             neg_rem;
  logic             dvs_zero;

  logic             accept;
  logic             early;
  logic [WIDTH-1:0] dvd_in_mag;
  logic [WIDTH-1:0] dvs_in_mag;
  logic [WIDTH-1:0] quo_step;
  logic [RW-1:0]    rem_step;

  // Magnitude of a two's-complement value; the most negative value maps to
  // itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                     is_signed);
    if (is_signed && v < 0)
      return (~v) + WIDTH'(1);
    else
      return v;
  endfunction

  // Conditional negation with natural WIDTH-bit wrap (no saturation).
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? (~v) + WIDTH'(1) : v;
  endfunction

  assign accept     = start & ~abort;
  assign dvd_in_mag = magnitude(dividend, signd);
  assign dvs_in_mag = magnitude(divider, signd);

`ifdef UPARC_IDIV_EARLY_OUT_EN
  assign early = (dvs_in_mag == '0) || (dvd_in_mag < dvs_in_mag);
`else
  assign early = 1'b0;
`endif

  // One radix-2^BITS_PER_CYCLE restoring step, unrolled into single-bit
  // shift/compare/subtract stages. The quotient register doubles as the
  // dividend shift register: dividend bits leave at the top while quotient
  // bits enter at the bottom.
  always_comb begin
    rem_step = rem_acc;
    quo_step = quo_acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_step = {rem_step[RW-2:0], quo_step[WIDTH-1]};
      quo_step = {quo_step[WIDTH-2:0], 1'b0};
      if (rem_step >= {{BITS_PER_CYCLE{1'b0}}, dvs_mag}) begin
        rem_step    = rem_step - {{BITS_PER_CYCLE{1'b0}}, dvs_mag};
        quo_step[0] = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = early ? S_FIX : S_RUN;
      S_RUN: begin
        if (abort)                  state_nxt = S_IDLE;
        else if (cnt == CNT_W'(1))  state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready = (state == S_IDLE);
  end

  // Control: iteration counter and architectural result
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt     <= '0;
      remquot <= '0;
      dz      <= 1'b0;
    end else begin
      if (state == S_IDLE && accept)
        cnt <= early ? '0 : CNT_W'(N);
      else if (state == S_RUN)
        cnt <= abort ? '0 : cnt - CNT_W'(1);

      // A zero divisor bypasses sign correction and reports the raw dividend.
      if (state == S_FIX && !abort) begin
        dz <= dvs_zero;
        if (dvs_zero)
          remquot <= {dvd_orig, {WIDTH{1'b1}}};
        else
          remquot <= {apply_sign(rem_acc[WIDTH-1:0], neg_rem),
                      apply_sign(quo_acc, neg_quo)};
      end
    end
  end

  // Datapath: operand capture and iteration (no reset needed)
  always_ff @(posedge clk) begin
    if (state == S_IDLE && accept) begin
      dvs_mag  <= dvs_in_mag;
      dvd_orig <= dividend;
      dvs_zero <= (divider == '0);
      neg_quo  <= signd & (dividend[WIDTH-1] ^ divider[WIDTH-1]);
      neg_rem  <= signd & dividend[WIDTH-1];
      if (early) begin
        // Quotient is zero and the whole magnitude is the remainder.
        quo_acc <= '0;
        rem_acc <= {{BITS_PER_CYCLE{1'b0}}, dvd_in_mag};
      end else begin
        quo_acc <= dvd_in_mag;
        rem_acc <= '0;
      end
    end else if (state == S_RUN) begin
      quo_acc <= quo_step;
      rem_acc <= rem_step;
    end
  end

endmodule

// File: tb/tb_uparc_iter_idiv.sv
module tb_uparc_iter_idiv;

  localparam int W   = 32;
  localparam int BPC = 1;
  localparam int N   = W / BPC;

  logic           clk;
  logic           nrst;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divider;
  logic           start;
  logic           signd;
  logic           abort;
  logic           ready;
  logic [2*W-1:0] remquot;
  logic           dz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]   dvd;
    logic [W-1:0]   dvs;
    logic           sgn;
    logic [2*W-1:0] exp_rq;
    logic           exp_dz;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] rq;
    logic           dzf;
    int             lat;
  } exp_t;

  exp_t sb[$];

  uparc_iter_idiv #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .nrst(nrst), .dividend(dividend), .divider(divider),
    .start(start), .signd(signd), .abort(abort),
    .ready(ready), .remquot(remquot), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
    return (s && v[W-1]) ? -v : v;
  endfunction

  // Reference result using native unsigned division on magnitudes.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    logic [W-1:0] ma, mb, q, r;
    ma = mag(a, s);
    mb = mag(b, s);
    if (b == 0) begin
      e.rq  = {a, {W{1'b1}}};
      e.dzf = 1'b1;
    end else begin
      q = ma / mb;
      r = ma % mb;
      if (s && (a[W-1] ^ b[W-1])) q = -q;
      if (s && a[W-1]) r = -r;
      e.rq  = {r, q};
      e.dzf = 1'b0;
    end
`ifdef UPARC_IDIV_EARLY_OUT_EN
    e.lat = (mb == 0 || ma < mb) ? 1 : N + 1;
`else
    e.lat = N + 1;
`endif
    return e;
  endfunction

  // Called at a negedge with ready=1; returns at the first negedge where
  // ready is high again, so consecutive calls are back-to-back.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input exp_t e, input string name);
    int lat;
    exp_t got;
    sb.push_back(e);
    dividend = a; divider = b; signd = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom; divider = $urandom; signd = $urandom_range(0, 1);
    lat = 0;
    while (!ready && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    got = sb.pop_front();
    check({name, " latency"}, 64'(lat), 64'(got.lat));
    check({name, " remquot"}, remquot, got.rq);
    check({name, " dz"}, 64'(dz), 64'(got.dzf));
  endtask

  vec_t vecs[14];

  initial begin
    exp_t e;
    int lat;
    logic [2*W-1:0] held;

    vecs[0]  = '{32'd100,      32'd7,        1'b0, {32'd2,        32'd14},       1'b0};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0};
    vecs[2]  = '{32'hFFFFFFF9, 32'd2,        1'b0, {32'd1,        32'h7FFFFFFC}, 1'b0};
    vecs[3]  = '{32'd5,        32'd0,        1'b1, {32'd5,        32'hFFFFFFFF}, 1'b1};
    vecs[4]  = '{32'd5,        32'd0,        1'b0, {32'd5,        32'hFFFFFFFF}, 1'b1};
    vecs[5]  = '{32'd9,        32'd3,        1'b1, {32'd0,        32'd3},        1'b0};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, {32'd0,        32'h80000000}, 1'b0};
    vecs[7]  = '{32'd3,        32'd10,       1'b0, {32'd3,        32'd0},        1'b0};
    vecs[8]  = '{32'd0,        32'd0,        1'b0, {32'd0,        32'hFFFFFFFF}, 1'b1};
    vecs[9]  = '{32'hFFFFFFF9, 32'd0,        1'b1, {32'hFFFFFFF9, 32'hFFFFFFFF}, 1'b1};
    vecs[10] = '{32'd7,        32'hFFFFFFFE, 1'b1, {32'd1,        32'hFFFFFFFD}, 1'b0};
    vecs[11] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, {32'hFFFFFFFF, 32'd3},        1'b0};
    vecs[12] = '{32'hFFFFFFFF, 32'd1,        1'b0, {32'd0,        32'hFFFFFFFF}, 1'b0};
    vecs[13] = '{32'hFFFFFFFD, 32'd10,       1'b1, {32'hFFFFFFFD, 32'd0},        1'b0};

    nrst = 1'b0; start = 1'b0; abort = 1'b0; signd = 1'b0;
    dividend = '0; divider = '0;
    #1;
    check("reset ready", 64'(ready), 64'd1);
    check("reset remquot", remquot, '0);
    check("reset dz", 64'(dz), 64'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      e = model(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn);
      e.rq  = vecs[i].exp_rq;
      e.dzf = vecs[i].exp_dz;
      run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn, e, $sformatf("vec%0d", i));
    end

    // Random operands against the reference model
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a, b;
      logic s;
      a = $urandom;
      b = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
      if (i % 4 == 3) b = -b;
      s = $urandom_range(0, 1);
      run_op(a, b, s, model(a, b, s), $sformatf("rnd%0d", i));
    end

    // Abort on RUN cycle 10 keeps the previous result
    run_op(32'd100, 32'd7, 1'b0, model(32'd100, 32'd7, 1'b0), "pre_abort");
    dividend = 32'd50; divider = 32'd5; signd = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort ready", 64'(ready), 64'd1);
    check("abort remquot", remquot, {32'd2, 32'd14});
    check("abort dz", 64'(dz), 64'd0);

    // start together with abort in IDLE captures nothing
    dividend = 32'd50; divider = 32'd5; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start+abort ready", 64'(ready), 64'd1);
    @(negedge clk);
    check("start+abort ready2", 64'(ready), 64'd1);
    check("start+abort remquot", remquot, {32'd2, 32'd14});

    // start while busy is ignored, nothing queued
    sb.push_back(model(32'd9, 32'd3, 1'b1));
    dividend = 32'd9; divider = 32'd3; signd = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!ready && lat < 200) begin
      lat++;
      if (lat == 4) begin
        dividend = 32'd100; divider = 32'd7; signd = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    check("busy latency", 64'(lat), 64'(e.lat));
    check("busy remquot", remquot, {32'd0, 32'd3});
    @(negedge clk);
    check("busy no queue", 64'(ready), 64'd1);

    // Reset mid-operation returns to reset values with no result
    dividend = 32'd100; divider = 32'd7; signd = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("midreset ready", 64'(ready), 64'd1);
    check("midreset remquot", remquot, '0);
    check("midreset dz", 64'(dz), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (N + 3) @(negedge clk);
    check("midreset no result", remquot, '0);

    // Operation still works after reset
    run_op(32'd100, 32'd7, 1'b0, model(32'd100, 32'd7, 1'b0), "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
